// File: rtl/fpu_cvt_sched.sv
// fpu_cvt_sched
// Shares one combinational FP32->FP64 widening converter between the load
// path (port 0) and the register-move path (port 1). One request is granted
// per cycle, round-robin on contention, and the converted value is pushed
// with its tag, origin port and source-exponent flags into a 2-entry result
// FIFO drained by the FPR writeback mux under valid/ready.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req0_* / req1_*             requester valid, FP32 operand, tag, ready
//   cvt_src / cvt_dst           operand to / result from the shared converter
//   res_valid/data/tag/port/flags, res_ready   FIFO head and pop handshake
//   busy                        FIFO holds at least one entry
//   stat_cnt0 / stat_cnt1       saturating per-port accepted-conversion counts
module fpu_cvt_sched #(
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [31:0]     req0_src,
    input  logic [TAGW-1:0] req0_tag,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [31:0]     req1_src,
    input  logic [TAGW-1:0] req1_tag,
    output logic            req1_ready,
    output logic [31:0]     cvt_src,
    input  logic [63:0]     cvt_dst,
    output logic            res_valid,
    output logic [63:0]     res_data,
    output logic [TAGW-1:0] res_tag,
    output logic            res_port,
    output logic [1:0]      res_flags,
    input  logic            res_ready,
    output logic            busy,
    output logic [15:0]     stat_cnt0,
    output logic [15:0]     stat_cnt1
);

    // bit0: zero exponent (converter flushes to +0), bit1: Inf/NaN exponent
    function automatic logic [1:0] src_flags(input logic [7:0] exp_bits);
        logic [1:0] f;
        f = 2'b00;
        if (exp_bits == 8'h00) begin
            f = 2'b01;
        end else if (exp_bits == 8'hFF) begin
            f = 2'b10;
        end else begin
            f = 2'b00;
        end
        return f;
    endfunction

    logic [1:0]      count_r;
    logic            head_r;
    logic            tail_r;
    logic            last_r;
    logic [15:0]     cnt0_r;
    logic [15:0]     cnt1_r;
    logic [63:0]     data_mem_r  [2];
    logic [TAGW-1:0] tag_mem_r   [2];
    logic            port_mem_r  [2];
    logic [1:0]      flags_mem_r [2];

    logic            space_s;
    logic            grant0_s;
    logic            grant1_s;
    logic            push_s;
    logic            pop_s;
    logic            head_valid_s;

    // Arbitration: space comes from the registered count only, so a pop in
    // the same cycle as a full FIFO does not open a slot until next cycle.
    always_comb begin
        space_s  = (count_r < 2'd2);
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!reset && space_s) begin
            if (req0_valid && req1_valid) begin
                // port that did not win last time gets it now
                if (last_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign push_s       = grant0_s | grant1_s;
    assign head_valid_s = (count_r != 2'd0);
    assign pop_s        = head_valid_s && res_ready && !reset;

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign cvt_src    = grant1_s ? req1_src : req0_src;

    assign res_valid = head_valid_s;
    assign busy      = head_valid_s;
    assign res_data  = head_valid_s ? data_mem_r[head_r]  : 64'd0;
    assign res_tag   = head_valid_s ? tag_mem_r[head_r]   : {TAGW{1'b0}};
    assign res_port  = head_valid_s ? port_mem_r[head_r]  : 1'b0;
    assign res_flags = head_valid_s ? flags_mem_r[head_r] : 2'b00;
    assign stat_cnt0 = cnt0_r;
    assign stat_cnt1 = cnt1_r;

    // FIFO storage, pointers, occupancy, round-robin state and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 2'd0;
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            last_r  <= 1'b1;
            cnt0_r  <= 16'd0;
            cnt1_r  <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                data_mem_r[i]  <= 64'd0;
                tag_mem_r[i]   <= {TAGW{1'b0}};
                port_mem_r[i]  <= 1'b0;
                flags_mem_r[i] <= 2'b00;
            end
        end else begin
            if (push_s) begin
                data_mem_r[tail_r]  <= cvt_dst;
                tag_mem_r[tail_r]   <= grant1_s ? req1_tag : req0_tag;
                port_mem_r[tail_r]  <= grant1_s;
                flags_mem_r[tail_r] <= src_flags(cvt_src[30:23]);
                tail_r              <= ~tail_r;
                last_r              <= grant1_s;
            end else begin
                tail_r <= tail_r;
                last_r <= last_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
            if (grant0_s && (cnt0_r != 16'hFFFF)) begin
                cnt0_r <= cnt0_r + 16'd1;
            end else begin
                cnt0_r <= cnt0_r;
            end
            if (grant1_s && (cnt1_r != 16'hFFFF)) begin
                cnt1_r <= cnt1_r + 16'd1;
            end else begin
                cnt1_r <= cnt1_r;
            end
        end
    end

endmodule

// File: tb/tb_fpu_cvt_sched.sv
module tb_fpu_cvt_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_src, req1_src;
    logic [3:0]  req0_tag, req1_tag;
    logic        req0_ready, req1_ready;
    logic [31:0] cvt_src;
    logic [63:0] cvt_dst;
    logic        res_valid;
    logic [63:0] res_data;
    logic [3:0]  res_tag;
    logic        res_port;
    logic [1:0]  res_flags;
    logic        res_ready;
    logic        busy;
    logic [15:0] stat_cnt0, stat_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared widening converter: zero exponent flushes to +0
    function automatic logic [63:0] to_fp64(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:23] == 8'h00) begin
            to_fp64 = 64'd0;
        end else if (s[30:23] == 8'hFF) begin
            to_fp64 = {s[31], 11'h7FF, s[22:0], 29'd0};
        end else begin
            e = {3'b000, s[30:23]} + 11'd896;
            to_fp64 = {s[31], e, s[22:0], 29'd0};
        end
    endfunction

    assign cvt_dst = to_fp64(cvt_src);

    fpu_cvt_sched #(.TAGW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_src   (req0_src),
        .req0_tag   (req0_tag),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_src   (req1_src),
        .req1_tag   (req1_tag),
        .req1_ready (req1_ready),
        .cvt_src    (cvt_src),
        .cvt_dst    (cvt_dst),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_port   (res_port),
        .res_flags  (res_flags),
        .res_ready  (res_ready),
        .busy       (busy),
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_src = 32'd0; req0_tag = 4'd0;
        req1_valid = 1'b0; req1_src = 32'd0; req1_tag = 4'd0;
        res_ready  = 1'b0;

        // ---- reset state, with requests presented during reset
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_src = 32'h3F800000; req1_src = 32'h40000000;
        #1;
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);
        tick();
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_data",  res_data, 64'd0);
        chk("rst_tag",   64'(res_tag), 64'd0);
        chk("rst_cnt0",  64'(stat_cnt0), 64'd0);
        chk("rst_cnt1",  64'(stat_cnt1), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;

        // ---- single request on port 0
        req0_valid = 1'b1; req0_src = 32'h3F800000; req0_tag = 4'd3;
        #1;
        chk("single_ready0", 64'(req0_ready), 64'd1);
        chk("single_ready1", 64'(req1_ready), 64'd0);
        chk("single_cvt_src", 64'(cvt_src), 64'h3F800000);
        tick();
        req0_valid = 1'b0;
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_data",  res_data, 64'h3FF0000000000000);
        chk("single_tag",   64'(res_tag), 64'd3);
        chk("single_port",  64'(res_port), 64'd0);
        chk("single_flags", 64'(res_flags), 64'd0);
        chk("single_cnt0",  64'(stat_cnt0), 64'd1);
        chk("single_busy",  64'(busy), 64'd1);
        res_ready = 1'b1;
        tick();
        chk("single_drained", 64'(res_valid), 64'd0);

        // ---- contention right after reset: 0,1,0,1
        do_reset();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_src = 32'h3F800000; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_src = 32'h40000000; req1_tag = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready0", 64'(req0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("cont_ready1", 64'(req1_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
            tick();
            chk("cont_port", 64'(res_port), (i % 2 == 1) ? 64'd1 : 64'd0);
            chk("cont_tag",  64'(res_tag), (i % 2 == 1) ? 64'd2 : 64'd1);
            chk("cont_data", res_data, (i % 2 == 1) ? 64'h4000000000000000 : 64'h3FF0000000000000);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("cont_drained", 64'(res_valid), 64'd0);
        chk("cont_cnt0", 64'(stat_cnt0), 64'd2);
        chk("cont_cnt1", 64'(stat_cnt1), 64'd2);

        // ---- backpressure on port 1
        do_reset();
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_src = 32'h3F800000; req1_tag = 4'd5;
        #1;
        chk("bp_acc1", 64'(req1_ready), 64'd1);
        tick();
        req1_src = 32'h40000000; req1_tag = 4'd6;
        #1;
        chk("bp_acc2", 64'(req1_ready), 64'd1);
        tick();
        req1_src = 32'hC0400000; req1_tag = 4'd7;
        #1;
        chk("bp_full_ready", 64'(req1_ready), 64'd0);
        tick();
        chk("bp_full_ready2", 64'(req1_ready), 64'd0);
        chk("bp_head_tag",  64'(res_tag), 64'd5);
        chk("bp_head_data", res_data, 64'h3FF0000000000000);
        chk("bp_head_port", 64'(res_port), 64'd1);
        res_ready = 1'b1;
        #1;
        chk("bp_pop_full_ready", 64'(req1_ready), 64'd0);
        tick();
        chk("bp_second_tag",  64'(res_tag), 64'd6);
        chk("bp_second_data", res_data, 64'h4000000000000000);
        chk("bp_resume_ready", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        chk("bp_third_tag",  64'(res_tag), 64'd7);
        chk("bp_third_data", res_data, 64'hC008000000000000);
        tick();
        chk("bp_drained", 64'(busy), 64'd0);
        chk("bp_cnt1", 64'(stat_cnt1), 64'd3);
        chk("bp_cnt0", 64'(stat_cnt0), 64'd0);

        // ---- flags
        do_reset();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_tag = 4'd9;
        req0_src = 32'h00400000;
        tick();
        chk("flag_denorm_data",  res_data, 64'd0);
        chk("flag_denorm_flags", 64'(res_flags), 64'd1);
        req0_src = 32'h7FC00000;
        tick();
        chk("flag_nan_data",  res_data, 64'h7FF8000000000000);
        chk("flag_nan_flags", 64'(res_flags), 64'd2);
        req0_src = 32'hFF800000;
        tick();
        chk("flag_ninf_data",  res_data, 64'hFFF0000000000000);
        chk("flag_ninf_flags", 64'(res_flags), 64'd2);
        req0_src = 32'h3F800000;
        tick();
        chk("flag_normal_flags", 64'(res_flags), 64'd0);
        req0_valid = 1'b0;

        // ---- saturation of stat_cnt0
        do_reset();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_src = 32'h3F800000;
        repeat (65534) tick();
        chk("sat_cnt0_fffe", 64'(stat_cnt0), 64'hFFFE);
        repeat (3) tick();
        chk("sat_cnt0_ffff", 64'(stat_cnt0), 64'hFFFF);
        chk("sat_cnt1", 64'(stat_cnt1), 64'd0);
        req0_valid = 1'b0;
        tick();

        // ---- reset mid-operation: fill FIFO leaving last = 0, then reset
        do_reset();
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_src = 32'h40000000; req1_tag = 4'd4;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_src = 32'h3F800000; req0_tag = 4'd8;
        tick();
        req1_valid = 1'b1;
        #1;
        chk("mid_full_ready0", 64'(req0_ready), 64'd0);
        chk("mid_full_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_valid", 64'(res_valid), 64'd0);
        chk("mid_busy",  64'(busy), 64'd0);
        chk("mid_data",  res_data, 64'd0);
        chk("mid_cnt0",  64'(stat_cnt0), 64'd0);
        chk("mid_cnt1",  64'(stat_cnt1), 64'd0);
        reset = 1'b0;
        #1;
        chk("mid_first_ready0", 64'(req0_ready), 64'd1);
        chk("mid_first_ready1", 64'(req1_ready), 64'd0);
        tick();
        chk("mid_post_port", 64'(res_port), 64'd0);
        chk("mid_post_cnt0", 64'(stat_cnt0), 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
